// File: rtl/topn_pkg.sv
// rtl/topn_pkg.sv - shared types and constants for the streaming top-N sorter
package topn_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic ASCEND  = 1'b1;
  localparam logic DESCEND = 1'b0;

  localparam int CELL_KEY_W = 8;
  localparam int CELL_TAG_W = 4;

  // Record layout of one ranked entry at the default widths; parametrised
  // modules carry the same three fields as separate signals.
  typedef struct packed {
    logic                  valid;
    logic [CELL_KEY_W-1:0] key;
    logic [CELL_TAG_W-1:0] tag;
  } cell_t;

endpackage

// File: rtl/topn_stream_sorter_if.sv
// rtl/topn_stream_sorter_if.sv - input/output stream handshakes of the top-N sorter
interface topn_stream_sorter_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_key;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_key;
  logic [TAG_W-1:0] out_tag;
  logic             out_last;

  modport master (
    output in_valid, in_key, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_key, out_tag, out_last
  );

  modport slave (
    input  in_valid, in_key, in_tag, flush, out_ready,
    output in_ready, out_valid, out_key, out_tag, out_last
  );

endinterface

// File: rtl/topn_cell.sv
// rtl/topn_cell.sv - one ranked entry of the sorter chain
module topn_cell
  import topn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [WIDTH-1:0] in_key,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             mode,
  input  logic             up_valid,
  input  logic             up_ge,
  input  logic [WIDTH-1:0] up_key,
  input  logic [TAG_W-1:0] up_tag,
  input  logic             dn_valid,
  input  logic [WIDTH-1:0] dn_key,
  input  logic [TAG_W-1:0] dn_tag,
  input  logic             shift_down,
  input  logic             shift_up,
  output logic             ge,
  output logic             valid,
  output logic [WIDTH-1:0] key,
  output logic [TAG_W-1:0] tag
);

  // Equal keys count as better-or-equal, so a newer equal key lands behind.
  assign ge = valid && ((mode == ASCEND) ? (key <= in_key) : (key >= in_key));

  always_ff @(posedge clk) begin
    if (!nreset) begin
      valid <= 1'b0;
      key   <= '0;
      tag   <= '0;
    end else if (shift_down) begin
      // The ge flags form a prefix; the first cell outside it takes the new key.
      if (!ge) begin
        if (up_ge) begin
          valid <= 1'b1;
          key   <= in_key;
          tag   <= in_tag;
        end else begin
          valid <= up_valid;
          key   <= up_key;
          tag   <= up_tag;
        end
      end
    end else if (shift_up) begin
      valid <= dn_valid;
      key   <= dn_key;
      tag   <= dn_tag;
    end
  end

endmodule

// File: rtl/topn_stream_sorter.sv
// rtl/topn_stream_sorter.sv - streaming top-N sorter: FSM, counters and cell chain
module topn_stream_sorter
  import topn_pkg::*;
#(
  parameter int N     = 22,
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     cfg_ascend,
  topn_stream_sorter_if.slave      bus,
  output logic [$clog2(N+1)-1:0]   count,
  output logic [15:0]              drop_cnt
);

  localparam int             CW  = $clog2(N+1);
  localparam logic [CW-1:0]  N_C = CW'(N);
  localparam logic [CW-1:0]  ONE = CW'(1);

  state_t          state;
  logic            mode_q;
  logic            in_ready_q;
  logic            insert;
  logic            pop;
  logic            drain;
  logic [CW-1:0]   fill_count_nxt;

  logic [N-1:0]     cv;
  logic [N-1:0]     ge;
  logic [WIDTH-1:0] ck [N];
  logic [TAG_W-1:0] ct [N];

  assign drain  = (state == DRAIN);
  assign insert = bus.in_valid & in_ready_q;
  assign pop    = drain & cv[0] & bus.out_ready;

  assign fill_count_nxt = (insert && (count != N_C)) ? count + ONE : count;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state      <= FILL;
      mode_q     <= DESCEND;
      in_ready_q <= 1'b0;
      count      <= '0;
      drop_cnt   <= '0;
    end else begin
      case (state)
        FILL: begin
          if (count == '0) mode_q <= cfg_ascend;
          count <= fill_count_nxt;
          if (insert && (count == N_C) && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;
          // An empty batch has nothing to drain, so stay ready for input.
          if (bus.flush && (fill_count_nxt != '0)) begin
            state      <= DRAIN;
            in_ready_q <= 1'b0;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (pop) begin
            count <= count - ONE;
            if (count == ONE) begin
              state      <= FILL;
              in_ready_q <= 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = drain & cv[0];
  assign bus.out_key   = ck[0];
  assign bus.out_tag   = ct[0];
  assign bus.out_last  = drain & (count == ONE);

  for (genvar i = 0; i < N; i++) begin : g_cell
    logic             up_v;
    logic             up_g;
    logic [WIDTH-1:0] up_k;
    logic [TAG_W-1:0] up_t;
    logic             dn_v;
    logic [WIDTH-1:0] dn_k;
    logic [TAG_W-1:0] dn_t;

    if (i == 0) begin : g_head
      assign up_v = 1'b0;
      assign up_g = 1'b1;
      assign up_k = '0;
      assign up_t = '0;
    end else begin : g_body
      assign up_v = cv[i-1];
      assign up_g = ge[i-1];
      assign up_k = ck[i-1];
      assign up_t = ct[i-1];
    end

    if (i == N-1) begin : g_tail
      assign dn_v = 1'b0;
      assign dn_k = '0;
      assign dn_t = '0;
    end else begin : g_link
      assign dn_v = cv[i+1];
      assign dn_k = ck[i+1];
      assign dn_t = ct[i+1];
    end

    topn_cell #(
      .WIDTH(WIDTH),
      .TAG_W(TAG_W)
    ) u_cell (
      .clk       (clk),
      .nreset    (nreset),
      .in_key    (bus.in_key),
      .in_tag    (bus.in_tag),
      .mode      (mode_q),
      .up_valid  (up_v),
      .up_ge     (up_g),
      .up_key    (up_k),
      .up_tag    (up_t),
      .dn_valid  (dn_v),
      .dn_key    (dn_k),
      .dn_tag    (dn_t),
      .shift_down(insert),
      .shift_up  (pop),
      .ge        (ge[i]),
      .valid     (cv[i]),
      .key       (ck[i]),
      .tag       (ct[i])
    );
  end

endmodule
